// File: rtl/stream_accumulator.sv
// Packet accumulator: sums NUM_WORDS streamed words through an external adder
// and presents the packet sum with a sticky overflow flag until it is consumed.
module stream_accumulator #(
  parameter int WIDTH     = 8,
  parameter int NUM_WORDS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  output logic [WIDTH-1:0] o_add1,
  output logic [WIDTH-1:0] o_add2,
  input  logic [WIDTH:0]   i_result,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_overflow,
  output logic             o_sum_valid,
  input  logic             i_sum_ready,
  output logic             o_busy
);

  localparam int CW_RAW = $clog2(NUM_WORDS + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             accept;

  assign accept = i_data_valid && (state_q != DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = i_result[WIDTH-1:0];
          ovf_d   = ovf_q | i_result[WIDTH];
          count_d = count_q + 1'b1;
          state_d = (count_d == LAST_COUNT) ? DONE : ACCUM;
        end
      end
      DONE: begin
        // Clearing here lets the next packet start from zero on the very next cycle.
        if (i_sum_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_add1       = acc_q;
  assign o_add2       = i_data;
  assign o_data_ready = (state_q != DONE);
  assign o_sum_valid  = (state_q == DONE);
  assign o_sum        = (state_q == DONE) ? acc_q : '0;
  assign o_overflow   = (state_q == DONE) ? ovf_q : 1'b0;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_stream_accumulator.sv
// Directed bench for stream_accumulator: a NUM_WORDS=4 instance driven from a
// vector table, plus a NUM_WORDS=1 instance and an overflow sequence by hand.
module tb_stream_accumulator;

  typedef struct {
    bit       rst;
    bit       vld;
    bit [7:0] data;
    bit       srdy;
    bit       rdy;
    bit       sv;
    bit [7:0] sum;
    bit       ovf;
    bit       busy;
    bit [7:0] add1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dataA, add1A, add2A, sumA;
  logic       vldA, rdyA, ovfA, svA, srdyA, busyA;
  logic [8:0] resultA;
  logic [7:0] dataB, add1B, add2B, sumB;
  logic       vldB, rdyB, ovfB, svB, srdyB, busyB;
  logic [8:0] resultB;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  // The external adder that the block is required to drive.
  assign resultA = {1'b0, add1A} + {1'b0, add2A};
  assign resultB = {1'b0, add1B} + {1'b0, add2B};

  stream_accumulator #(.WIDTH(8), .NUM_WORDS(4)) dutA (
    .i_clk(clk), .i_rst(rst), .i_data(dataA), .i_data_valid(vldA),
    .o_data_ready(rdyA), .o_add1(add1A), .o_add2(add2A), .i_result(resultA),
    .o_sum(sumA), .o_overflow(ovfA), .o_sum_valid(svA),
    .i_sum_ready(srdyA), .o_busy(busyA)
  );

  stream_accumulator #(.WIDTH(8), .NUM_WORDS(1)) dutB (
    .i_clk(clk), .i_rst(rst), .i_data(dataB), .i_data_valid(vldB),
    .o_data_ready(rdyB), .o_add1(add1B), .o_add2(add2B), .i_result(resultB),
    .o_sum(sumB), .o_overflow(ovfB), .o_sum_valid(svB),
    .i_sum_ready(srdyB), .o_busy(busyB)
  );

  function automatic vec_t mk(bit r, bit v, bit [7:0] d, bit s, bit erdy,
                              bit esv, bit [7:0] esum, bit eovf, bit ebusy,
                              bit [7:0] eadd1);
    vec_t t;
    t.rst = r; t.vld = v; t.data = d; t.srdy = s;
    t.rdy = erdy; t.sv = esv; t.sum = esum; t.ovf = eovf; t.busy = ebusy;
    t.add1 = eadd1;
    return t;
  endfunction

  task automatic checkField(input string name, input int idx,
                            input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s vec=%0d actual=%0h expected=%0h", name, idx,
               actual, expected);
    end
  endtask

  task automatic checkOutput(input vec_t t, input int idx, input bit useB);
    if (!useB) begin
      checkField("ready", idx, int'(rdyA), int'(t.rdy));
      checkField("sum_valid", idx, int'(svA), int'(t.sv));
      checkField("sum", idx, int'(sumA), int'(t.sum));
      checkField("overflow", idx, int'(ovfA), int'(t.ovf));
      checkField("busy", idx, int'(busyA), int'(t.busy));
      checkField("add1", idx, int'(add1A), int'(t.add1));
      checkField("add2", idx, int'(add2A), int'(t.data));
    end else begin
      checkField("B_ready", idx, int'(rdyB), int'(t.rdy));
      checkField("B_sum_valid", idx, int'(svB), int'(t.sv));
      checkField("B_sum", idx, int'(sumB), int'(t.sum));
      checkField("B_overflow", idx, int'(ovfB), int'(t.ovf));
      checkField("B_busy", idx, int'(busyB), int'(t.busy));
      checkField("B_add1", idx, int'(add1B), int'(t.add1));
    end
  endtask

  // Inputs change on the falling edge; outputs reflect state before the next rising edge.
  task automatic applyStimulus(input vec_t t, input int idx, input bit useB);
    @(negedge clk);
    rst = t.rst;
    if (!useB) begin
      vldA = t.vld; dataA = t.data; srdyA = t.srdy;
    end else begin
      vldB = t.vld; dataB = t.data; srdyB = t.srdy;
    end
    #1;
    checkOutput(t, idx, useB);
  endtask

  initial begin
    rst = 1'b1;
    vldA = 1'b0; dataA = 8'h00; srdyA = 1'b0;
    vldB = 1'b0; dataB = 8'h00; srdyB = 1'b0;
    repeat (2) @(posedge clk);

    //            rst vld data  srdy rdy sv sum   ovf busy add1
    vecs.push_back(mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0, 8'h00));
    // 1,2,3,4 back-to-back
    vecs.push_back(mk(0, 1, 8'h01, 1,  1, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h02, 1,  1, 0, 8'h00, 0, 1, 8'h01));
    vecs.push_back(mk(0, 1, 8'h03, 1,  1, 0, 8'h00, 0, 1, 8'h03));
    vecs.push_back(mk(0, 1, 8'h04, 1,  1, 0, 8'h00, 0, 1, 8'h06));
    vecs.push_back(mk(0, 0, 8'h00, 1,  0, 1, 8'd10, 0, 1, 8'd10));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0, 8'h00));
    // wrap with overflow, then a clean packet straight after DONE
    vecs.push_back(mk(0, 1, 8'hFF, 1,  1, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h02, 1,  1, 0, 8'h00, 0, 1, 8'hFF));
    vecs.push_back(mk(0, 1, 8'h00, 1,  1, 0, 8'h00, 0, 1, 8'h01));
    vecs.push_back(mk(0, 1, 8'h00, 1,  1, 0, 8'h00, 0, 1, 8'h01));
    vecs.push_back(mk(0, 0, 8'h00, 1,  0, 1, 8'h01, 1, 1, 8'h01));
    vecs.push_back(mk(0, 1, 8'h01, 1,  1, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h01, 1,  1, 0, 8'h00, 0, 1, 8'h01));
    vecs.push_back(mk(0, 1, 8'h01, 1,  1, 0, 8'h00, 0, 1, 8'h02));
    vecs.push_back(mk(0, 1, 8'h01, 1,  1, 0, 8'h00, 0, 1, 8'h03));
    vecs.push_back(mk(0, 0, 8'h00, 1,  0, 1, 8'h04, 0, 1, 8'h04));
    // valid toggling with words of 5
    vecs.push_back(mk(0, 1, 8'h05, 1,  1, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h05, 1,  1, 0, 8'h00, 0, 1, 8'h05));
    vecs.push_back(mk(0, 1, 8'h05, 1,  1, 0, 8'h00, 0, 1, 8'h05));
    vecs.push_back(mk(0, 0, 8'h05, 1,  1, 0, 8'h00, 0, 1, 8'd10));
    vecs.push_back(mk(0, 1, 8'h05, 1,  1, 0, 8'h00, 0, 1, 8'd10));
    vecs.push_back(mk(0, 0, 8'h05, 1,  1, 0, 8'h00, 0, 1, 8'd15));
    vecs.push_back(mk(0, 1, 8'h05, 1,  1, 0, 8'h00, 0, 1, 8'd15));
    vecs.push_back(mk(0, 0, 8'h00, 1,  0, 1, 8'd20, 0, 1, 8'd20));
    // back-pressure: DONE held 5 cycles with valid high, then released
    vecs.push_back(mk(0, 1, 8'h02, 0,  1, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h02, 0,  1, 0, 8'h00, 0, 1, 8'h02));
    vecs.push_back(mk(0, 1, 8'h02, 0,  1, 0, 8'h00, 0, 1, 8'h04));
    vecs.push_back(mk(0, 1, 8'h02, 0,  1, 0, 8'h00, 0, 1, 8'h06));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 8'h09, 0,  0, 1, 8'h08, 0, 1, 8'h08));
    vecs.push_back(mk(0, 1, 8'h09, 1,  0, 1, 8'h08, 0, 1, 8'h08));
    vecs.push_back(mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0, 8'h00));
    // reset after two words, colliding with a third accept
    vecs.push_back(mk(0, 1, 8'h07, 1,  1, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h07, 1,  1, 0, 8'h00, 0, 1, 8'h07));
    vecs.push_back(mk(1, 1, 8'h07, 1,  1, 0, 8'h00, 0, 1, 8'd14));
    vecs.push_back(mk(1, 1, 8'h07, 1,  1, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h07, 0,  1, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h07, 0,  1, 0, 8'h00, 0, 1, 8'h07));
    vecs.push_back(mk(0, 1, 8'h07, 0,  1, 0, 8'h00, 0, 1, 8'd14));
    vecs.push_back(mk(0, 1, 8'h07, 0,  1, 0, 8'h00, 0, 1, 8'd21));
    // reset while DONE with the handshake also asserted discards the sum
    vecs.push_back(mk(1, 0, 8'h00, 1,  0, 1, 8'd28, 0, 1, 8'd28));
    vecs.push_back(mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0, 8'h00));

    foreach (vecs[i]) applyStimulus(vecs[i], i, 1'b0);

    // NUM_WORDS=1: 9 then 3, the 3 first offered while DONE and held off
    vecs.delete();
    vecs.push_back(mk(0, 1, 8'h09, 1,  1, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h03, 1,  0, 1, 8'h09, 0, 1, 8'h09));
    vecs.push_back(mk(0, 1, 8'h03, 1,  1, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 1,  0, 1, 8'h03, 0, 1, 8'h03));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0, 8'h00));
    foreach (vecs[i]) applyStimulus(vecs[i], 100 + i, 1'b1);

    // Four words of 0x80 overflow twice and wrap to 0; wait is bounded.
    begin
      int waited = 0;
      @(negedge clk);
      srdyA = 1'b0; vldA = 1'b1; dataA = 8'h80;
      repeat (4) @(negedge clk);
      vldA = 1'b0; dataA = 8'h00;
      #1;
      while (!svA && waited < 8) begin
        @(negedge clk); #1;
        waited++;
      end
      checkField("ovf_seq_timeout", 200, waited, 0);
      checkField("ovf_seq_sum", 200, int'(sumA), 0);
      checkField("ovf_seq_overflow", 200, int'(ovfA), 1);
      @(negedge clk);
      srdyA = 1'b1;
      @(negedge clk); #1;
      checkField("ovf_seq_release", 201, int'(svA), 0);
      checkField("ovf_seq_cleared", 201, int'(ovfA), 0);
      srdyA = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
